// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: serial line, frame configuration and received-byte outputs.
// master drives RX_IN/config and observes results; slave is the receiver.
interface uart_rx_deser_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
);
    logic                   RX_IN;
    logic [PRESC_WIDTH-1:0] Prescale;
    logic                   parity_enable;
    logic                   parity_type;
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   data_valid;
    logic                   parity_error;
    logic                   framing_error;

    modport master (
        output RX_IN, Prescale, parity_enable, parity_type,
        input  P_DATA, data_valid, parity_error, framing_error
    );

    modport slave (
        input  RX_IN, Prescale, parity_enable, parity_type,
        output P_DATA, data_valid, parity_error, framing_error
    );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receiver, 3-sample majority vote per bit.
// Ports: CLK, RST (async active-low), bus (slave: line/config in, byte/pulses out).
module uart_rx_deser #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_deser_if.slave bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam int PW = PRESC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t r_state, w_next;

    logic [PW-1:0]         r_presc;
    logic [PW-1:0]         r_edge;
    logic                  r_par_en;
    logic                  r_par_type;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_smp;
    logic                  r_stop;
    logic                  r_par_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_ferr;

    logic [PW-1:0] w_half;
    logic          w_maj;
    logic          w_at_vote;
    logic          w_at_last;
    logic          w_start;

    assign w_half    = r_presc >> 1;
    assign w_maj     = (r_smp[0] & r_smp[1]) |
                       (r_smp[0] & r_smp[2]) |
                       (r_smp[1] & r_smp[2]);
    assign w_at_vote = (r_edge == w_half + PW'(2));
    assign w_at_last = (r_edge == r_presc - PW'(1));
    assign w_start   = (r_state == S_IDLE) && !bus.RX_IN;

    assign bus.P_DATA        = r_data;
    assign bus.data_valid    = r_valid;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (!bus.RX_IN) w_next = S_START;
            S_START: begin
                if (w_at_vote && w_maj) w_next = S_IDLE;
                else if (w_at_last)     w_next = S_DATA;
            end
            S_DATA: begin
                if (w_at_last && r_bit_cnt == LAST_BIT)
                    w_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_at_last) w_next = S_STOP;
            S_STOP:   if (w_at_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc    <= '0;
            r_edge     <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_smp      <= '0;
            r_stop     <= 1'b0;
            r_par_err  <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;

            // The detect cycle is edge 0 of the start bit, so START opens at 1.
            if (w_start) begin
                r_presc    <= bus.Prescale;
                r_par_en   <= bus.parity_enable;
                r_par_type <= bus.parity_type;
                r_par_err  <= 1'b0;
                r_edge     <= PW'(1);
            end else if (r_state != S_IDLE) begin
                if (r_state == S_START && w_at_vote && w_maj)
                    r_edge <= '0;
                else
                    r_edge <= w_at_last ? '0 : r_edge + PW'(1);
            end

            if (r_state != S_IDLE) begin
                if (r_edge == w_half - PW'(1)) r_smp[0] <= bus.RX_IN;
                if (r_edge == w_half)          r_smp[1] <= bus.RX_IN;
                if (r_edge == w_half + PW'(1)) r_smp[2] <= bus.RX_IN;
            end

            if (w_at_vote) begin
                unique case (1'b1)
                    r_state == S_DATA:
                        r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    r_state == S_PARITY:
                        r_par_err <= w_maj ^ (^r_shift) ^ r_par_type;
                    r_state == S_STOP:
                        r_stop <= w_maj;
                    default: ;
                endcase
            end

            if (r_state == S_START)
                r_bit_cnt <= '0;
            else if (r_state == S_DATA && w_at_last)
                r_bit_cnt <= r_bit_cnt + BW'(1);

            if (r_state == S_STOP && w_at_last) begin
                if (r_stop && !r_par_err) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
                r_ferr <= !r_stop;
                r_perr <= r_par_err;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: frame-level reference model, directed plus random frames.
// Checks pulse timing at N*P cycles after start-detect and P_DATA contents.
module tb_uart_rx_deser;
    logic CLK;
    logic RST;

    uart_rx_deser_if #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) bus ();

    uart_rx_deser #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    int         stray = 0;
    bit         pend  = 0;
    logic [2:0] exp_f;
    logic [7:0] model = 8'h00;
    string      etag  = "";

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One line cycle: drive RX_IN, inspect the outputs visible this cycle.
    task automatic cyc(input logic rx);
        logic [2:0] f;
        bus.RX_IN = rx;
        f = {bus.data_valid, bus.parity_error, bus.framing_error};
        if (pend) begin
            chk({etag, "_flags"}, 32'(f), 32'(exp_f));
            chk({etag, "_pdata"}, 32'(bus.P_DATA), 32'(model));
            pend = 0;
        end else if (f != 3'b000) begin
            stray++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int p, input bit pen,
                        input bit pty, input bit stp, input bit badp,
                        input bit chg, input string tag);
        logic bits[$];
        logic pb;
        int   n;
        bit   perr, ferr, ok;
        bus.Prescale      = 6'(p);
        bus.parity_enable = pen;
        bus.parity_type   = pty;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) begin
            pb = (^d) ^ pty ^ badp;
            bits.push_back(pb);
        end
        bits.push_back(stp);
        n = 0;
        foreach (bits[k]) begin
            for (int c = 0; c < p; c++) begin
                if (chg && n == 20) bus.Prescale = 6'd16;
                cyc(bits[k]);
                n++;
            end
        end
        perr  = pen && badp;
        ferr  = !stp;
        ok    = !perr && !ferr;
        exp_f = {ok, perr, ferr};
        if (ok) model = d;
        etag = tag;
        pend = 1;
    endtask

    task automatic chk_stray(input string tag);
        chk({tag, "_stray"}, 32'(stray), 32'd0);
        stray = 0;
    endtask

    initial begin
        RST               = 1'b0;
        bus.RX_IN         = 1'b1;
        bus.Prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        #1;
        chk("rst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("rst_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_perr", 32'(bus.parity_error), 32'h0);
        chk("rst_ferr", 32'(bus.framing_error), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (4) cyc(1'b1);

        send(8'hA5, 8, 0, 0, 1, 0, 0, "p8_a5");
        repeat (5) cyc(1'b1);
        send(8'h3C, 16, 1, 0, 1, 0, 0, "p16_even");
        cyc(1'b1);
        send(8'h3C, 16, 1, 1, 1, 0, 0, "p16_odd");
        cyc(1'b1);
        send(8'hA5, 8, 0, 0, 1, 0, 0, "p8_a5_again");
        cyc(1'b1);
        send(8'h01, 8, 1, 0, 1, 1, 0, "p8_parerr");
        cyc(1'b1);
        send(8'hFF, 32, 0, 0, 0, 0, 0, "p32_frame");
        cyc(1'b1);
        send(8'h55, 32, 0, 0, 1, 0, 0, "p32_55");
        cyc(1'b1);
        chk_stray("directed");

        bus.Prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        repeat (20) cyc(1'b1);
        chk_stray("glitch");

        send(8'h12, 8, 0, 0, 1, 0, 0, "b2b_12");
        send(8'h34, 8, 0, 0, 1, 0, 0, "b2b_34");
        cyc(1'b1);
        chk_stray("b2b");

        send(8'h00, 8, 0, 0, 0, 0, 0, "held_low");
        send(8'h66, 8, 0, 0, 1, 0, 0, "after_low");
        cyc(1'b1);

        bus.Prescale = 6'd8;
        repeat (8) cyc(1'b0);
        repeat (24) cyc(1'b1);
        RST       = 1'b0;
        bus.RX_IN = 1'b1;
        model     = 8'h00;
        #1;
        chk("async_rst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("async_rst_flags",
            32'({bus.data_valid, bus.parity_error, bus.framing_error}), 32'h0);
        @(posedge CLK);
        #1;
        repeat (3) cyc(1'b1);
        RST = 1'b1;
        repeat (3) cyc(1'b1);
        chk_stray("reset");
        send(8'h77, 8, 0, 0, 1, 0, 0, "post_rst");
        cyc(1'b1);
        send(8'h9C, 8, 0, 0, 1, 0, 1, "presc_chg");
        cyc(1'b1);
        chk_stray("presc_chg");

        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            int         p;
            bit         pen, pty, stp, badp;
            int         gap;
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pen  = 1'($urandom);
            pty  = 1'($urandom);
            stp  = ($urandom_range(0, 4) != 0);
            badp = pen && ($urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 3);
            send(d, p, pen, pty, stp, badp, 0, "rand");
            for (int g = 0; g < gap; g++) cyc(1'b1);
        end
        repeat (4) cyc(1'b1);
        chk_stray("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
